// File: rtl/rs_dispatch_sched.sv
// Wakeup-select scheduler for the centralized reservation station: oldest-first
// pick per execution port, divider sequencing and MUL/DIV shared-CDB slot reservation.
module rs_dispatch_sched #(
    parameter int RS_NUM_ENTRIES      = 16,
    parameter int RS_NUM_ENTRIES_CLOG = $clog2(RS_NUM_ENTRIES),
    parameter int ISSUE_WIDTH_MAX     = 2,
    parameter int MUL_LAT             = 3,
    parameter int DIV_LAT             = 8
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic [RS_NUM_ENTRIES-1:0]                      ety_valid,
    input  logic [RS_NUM_ENTRIES-1:0]                      ety_rdy,
    input  logic [2*RS_NUM_ENTRIES-1:0]                    ety_fu,
    input  logic [ISSUE_WIDTH_MAX-1:0]                     alloc_val,
    input  logic [ISSUE_WIDTH_MAX*RS_NUM_ENTRIES_CLOG-1:0] alloc_idx,
    input  logic                                           flush,
    input  logic [4:0]                                     port_stall,
    output logic [4:0]                                     disp_val,
    output logic [5*RS_NUM_ENTRIES_CLOG-1:0]               disp_idx,
    output logic [RS_NUM_ENTRIES-1:0]                      disp_clr,
    output logic                                           div_busy
);
    localparam int N  = RS_NUM_ENTRIES;
    localparam int W  = RS_NUM_ENTRIES_CLOG;
    localparam int IW = ISSUE_WIDTH_MAX;
    localparam int CW = $clog2(DIV_LAT + 1);

    typedef enum logic [1:0] {FU_ALU = 2'd0, FU_MUL = 2'd1, FU_DIV = 2'd2, FU_LSU = 2'd3} fu_e;
    typedef struct packed {
        logic         found;
        logic [W-1:0] idx;
    } pick_t;

    logic [N-1:0]       age_q [N];
    logic [N-1:0]       age_d [N];
    logic [DIV_LAT-1:0] wb_rsv, wb_d, rsv_set;
    logic [CW-1:0]      div_cnt, cnt_d;
    logic [N-1:0]       cand_alu, cand_mul, cand_div, cand_lsu;
    pick_t              alu_a, alu_b, mul_p, div_p, lsu_p;
    pick_t              grant [5];
    logic [4:0]         ok;
    logic               en;

    // Oldest candidate = the one no other candidate is older than.
    function automatic pick_t pick_oldest(input logic [N-1:0] cand, input logic [N-1:0] age [N]);
        pick_t p;
        logic  blocked;
        p = '0;
        for (int unsigned i = 0; i < N; i++) begin
            blocked = 1'b0;
            for (int unsigned j = 0; j < N; j++) begin
                if (cand[j] && age[j][i]) blocked = 1'b1;
            end
            if (!p.found && cand[i] && !blocked) begin
                p.found = 1'b1;
                p.idx   = W'(i);
            end
        end
        return p;
    endfunction

    function automatic logic [N-1:0] onehot(input pick_t p);
        logic [N-1:0] v;
        v = '0;
        if (p.found) v[p.idx] = 1'b1;
        return v;
    endfunction

    assign div_busy = (div_cnt != '0);

    always_comb begin
        cand_alu = '0;
        cand_mul = '0;
        cand_div = '0;
        cand_lsu = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (ety_valid[i] && ety_rdy[i]) begin
                case (fu_e'(ety_fu[2*i +: 2]))
                    FU_ALU:  cand_alu[i] = 1'b1;
                    FU_MUL:  cand_mul[i] = 1'b1;
                    FU_DIV:  cand_div[i] = 1'b1;
                    default: cand_lsu[i] = 1'b1;
                endcase
            end
        end
    end

    always_comb begin
        alu_a = pick_oldest(cand_alu, age_q);
        alu_b = pick_oldest(cand_alu & ~onehot(alu_a), age_q);
        mul_p = pick_oldest(cand_mul, age_q);
        div_p = pick_oldest(cand_div, age_q);
        lsu_p = pick_oldest(cand_lsu, age_q);
    end

    always_comb begin
        en       = rst & ~flush;
        grant[0] = alu_a;
        grant[1] = port_stall[0] ? alu_a : alu_b;
        grant[2] = mul_p;
        grant[3] = div_p;
        grant[4] = lsu_p;
        ok[0] = alu_a.found & ~port_stall[0];
        ok[1] = (port_stall[0] ? alu_a.found : alu_b.found) & ~port_stall[1];
        ok[2] = mul_p.found & ~port_stall[2] & ~wb_rsv[MUL_LAT-1];
        ok[3] = div_p.found & ~port_stall[3] & ~div_busy & ~wb_rsv[DIV_LAT-1];
        ok[4] = lsu_p.found & ~port_stall[4];
        // Same-cycle MUL/DIV grants can only share a writeback slot if the latencies match.
        if (MUL_LAT == DIV_LAT && ok[2] && ok[3]) begin
            if (age_q[div_p.idx][mul_p.idx]) ok[2] = 1'b0;
            else                             ok[3] = 1'b0;
        end
        disp_clr = '0;
        for (int unsigned k = 0; k < 5; k++) begin
            disp_val[k]         = ok[k] & en;
            disp_idx[k*W +: W]  = disp_val[k] ? grant[k].idx : '0;
            if (disp_val[k]) disp_clr[grant[k].idx] = 1'b1;
        end
    end

    // Row clears for every allocated entry come first so lower-slot age bits survive.
    always_comb begin
        age_d = age_q;
        for (int unsigned s = 0; s < IW; s++) begin
            if (alloc_val[s]) age_d[alloc_idx[s*W +: W]] = '0;
        end
        for (int unsigned s = 0; s < IW; s++) begin
            if (alloc_val[s]) begin
                for (int unsigned j = 0; j < N; j++) begin
                    if (ety_valid[j] && (W'(j) != alloc_idx[s*W +: W]))
                        age_d[j][alloc_idx[s*W +: W]] = 1'b1;
                end
                for (int unsigned t = 0; t < s; t++) begin
                    if (alloc_val[t]) age_d[alloc_idx[t*W +: W]][alloc_idx[s*W +: W]] = 1'b1;
                end
            end
        end
        rsv_set = '0;
        if (disp_val[2]) rsv_set[MUL_LAT-1] = 1'b1;
        if (disp_val[3]) rsv_set[DIV_LAT-1] = 1'b1;
        wb_d = (wb_rsv | rsv_set) >> 1;
        if (disp_val[3])          cnt_d = CW'(DIV_LAT - 1);
        else if (div_cnt != '0)   cnt_d = div_cnt - CW'(1);
        else                      cnt_d = div_cnt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < N; i++) age_q[i] <= '0;
            wb_rsv  <= '0;
            div_cnt <= '0;
        end else if (flush) begin
            for (int unsigned i = 0; i < N; i++) age_q[i] <= '0;
            wb_rsv  <= '0;
            div_cnt <= '0;
        end else begin
            for (int unsigned i = 0; i < N; i++) age_q[i] <= age_d[i];
            wb_rsv  <= wb_d;
            div_cnt <= cnt_d;
        end
    end
endmodule

// File: tb/tb_rs_dispatch_sched.sv
// Scoreboard bench for rs_dispatch_sched: directed steps push hand-computed
// per-cycle dispatch expectations; a monitor pops and compares them.
module tb_rs_dispatch_sched;
    localparam int N = 16;
    localparam logic [1:0] ALU = 2'd0, MUL = 2'd1, DIV = 2'd2, LSU = 2'd3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [N-1:0]  ety_valid = '0;
    logic [N-1:0]  ety_rdy = '0;
    logic [2*N-1:0] ety_fu = '0;
    logic [1:0]    alloc_val = '0;
    logic [7:0]    alloc_idx = '0;
    logic          flush = 1'b0;
    logic [4:0]    port_stall = '0;
    logic [4:0]    disp_val;
    logic [19:0]   disp_idx;
    logic [N-1:0]  disp_clr;
    logic          div_busy;

    rs_dispatch_sched #(
        .RS_NUM_ENTRIES(16), .ISSUE_WIDTH_MAX(2), .MUL_LAT(3), .DIV_LAT(8)
    ) dut (
        .clk(clk), .rst(rst), .ety_valid(ety_valid), .ety_rdy(ety_rdy), .ety_fu(ety_fu),
        .alloc_val(alloc_val), .alloc_idx(alloc_idx), .flush(flush), .port_stall(port_stall),
        .disp_val(disp_val), .disp_idx(disp_idx), .disp_clr(disp_clr), .div_busy(div_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          tag;
        logic [4:0]  val;
        logic [19:0] idx;
        logic [15:0] clr;
        logic        busy;
    } exp_t;

    exp_t sb[$];
    event mon_ev;
    int   compared = 0;
    int   mismatched = 0;
    int   step_no = 0;

    task automatic chk(input string nm, input int tag, input logic [31:0] got, input logic [31:0] want);
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("FAIL %s step %0d: got %0h want %0h", nm, tag, got, want);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk or mon_ev);
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("disp_val", e.tag, 32'(disp_val), 32'(e.val));
                chk("disp_idx", e.tag, 32'(disp_idx), 32'(e.idx));
                chk("disp_clr", e.tag, 32'(disp_clr), 32'(e.clr));
                chk("div_busy", e.tag, 32'(div_busy), 32'(e.busy));
            end
        end
    end

    // ev bit order: 0 ALU0, 1 ALU1, 2 MUL, 3 DIV, 4 LSU
    task automatic push(input logic [4:0] ev, input logic [3:0] a0, a1, m, d, l, input logic bz);
        exp_t e;
        e.tag  = step_no;
        e.val  = ev;
        e.idx  = {l, d, m, a1, a0};
        e.clr  = '0;
        for (int k = 0; k < 5; k++) if (ev[k]) e.clr[e.idx[k*4 +: 4]] = 1'b1;
        e.busy = bz;
        sb.push_back(e);
    endtask

    // One cycle; afterwards the bench acts as the RS: clears granted entries,
    // marks allocated entries valid, and drops everything on flush.
    task automatic step(input logic [4:0] ev, input logic [3:0] a0, a1, m, d, l, input logic bz);
        logic [19:0] ix;
        ix = {l, d, m, a1, a0};
        push(ev, a0, a1, m, d, l, bz);
        @(posedge clk);
        #1;
        for (int k = 0; k < 5; k++) if (ev[k]) ety_valid[ix[k*4 +: 4]] = 1'b0;
        for (int s = 0; s < 2; s++) if (alloc_val[s]) ety_valid[alloc_idx[s*4 +: 4]] = 1'b1;
        alloc_val = '0;
        if (flush) ety_valid = '0;
        flush = 1'b0;
        step_no++;
    endtask

    task automatic al(input int s, input int e, input logic [1:0] fu, input logic r);
        alloc_val[s]          = 1'b1;
        alloc_idx[s*4 +: 4]   = 4'(e);
        ety_fu[2*e +: 2]      = fu;
        ety_rdy[e]            = r;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        @(posedge clk);
        #1;
        step(5'b00000, 0, 0, 0, 0, 0, 0);                 // reset held
        rst = 1'b1;
        // age order across cycles and within one cycle
        al(0, 5, ALU, 0);  step(5'b00000, 0, 0, 0, 0, 0, 0);
        al(0, 2, ALU, 0);  step(5'b00000, 0, 0, 0, 0, 0, 0);
        ety_rdy[5] = 1'b1; ety_rdy[2] = 1'b1;
        step(5'b00011, 5, 2, 0, 0, 0, 0);
        al(0, 9, ALU, 1);  al(1, 3, ALU, 1);
        step(5'b00000, 0, 0, 0, 0, 0, 0);
        step(5'b00011, 9, 3, 0, 0, 0, 0);
        // ALU0 stalled
        al(0, 7, ALU, 0);  step(5'b00000, 0, 0, 0, 0, 0, 0);
        al(0, 1, ALU, 0);  step(5'b00000, 0, 0, 0, 0, 0, 0);
        al(0, 12, ALU, 0); step(5'b00000, 0, 0, 0, 0, 0, 0);
        ety_rdy[7] = 1'b1; ety_rdy[1] = 1'b1; ety_rdy[12] = 1'b1;
        port_stall = 5'b00001;
        step(5'b00010, 0, 7, 0, 0, 0, 0);
        port_stall = 5'b00000;
        step(5'b00011, 1, 12, 0, 0, 0, 0);
        // divider busy and CDB collision
        al(0, 4, DIV, 1);  al(1, 6, DIV, 1);
        step(5'b00000, 0, 0, 0, 0, 0, 0);
        al(0, 10, MUL, 0);
        step(5'b01000, 0, 0, 0, 4, 0, 0);                 // t
        for (int k = 0; k < 4; k++) step(5'b00000, 0, 0, 0, 0, 0, 1);
        ety_rdy[10] = 1'b1;
        step(5'b00000, 0, 0, 0, 0, 0, 1);                 // t+5 MUL blocked
        step(5'b00100, 0, 0, 10, 0, 0, 1);                // t+6
        step(5'b00000, 0, 0, 0, 0, 0, 1);                 // t+7
        step(5'b01000, 0, 0, 0, 6, 0, 0);                 // t+8
        // flush during division
        al(0, 0, LSU, 1);  al(1, 8, ALU, 1);
        step(5'b00000, 0, 0, 0, 0, 0, 1);
        flush = 1'b1;      al(0, 13, ALU, 1);
        step(5'b00000, 0, 0, 0, 0, 0, 1);
        al(0, 3, ALU, 1);  al(1, 9, ALU, 1);
        step(5'b00000, 0, 0, 0, 0, 0, 0);
        al(0, 14, LSU, 1); al(1, 1, MUL, 1);
        step(5'b00011, 3, 9, 0, 0, 0, 0);
        al(0, 2, DIV, 1);  al(1, 5, ALU, 1);
        step(5'b10100, 0, 0, 1, 0, 14, 0);
        al(0, 7, ALU, 1);
        step(5'b01001, 5, 0, 0, 2, 0, 0);
        // asynchronous reset between edges during a division
        push(5'b00001, 7, 0, 0, 0, 0, 1);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        push(5'b00000, 0, 0, 0, 0, 0, 0);
        ->mon_ev;
        @(posedge clk);
        #1;
        ety_valid = '0;
        step_no++;
        rst = 1'b1;
        al(0, 4, DIV, 1);  al(1, 11, MUL, 1);
        step(5'b00000, 0, 0, 0, 0, 0, 0);
        step(5'b01100, 0, 0, 11, 4, 0, 0);                // divider free right after release
        al(0, 6, MUL, 1);  al(1, 8, MUL, 1);
        step(5'b00000, 0, 0, 0, 0, 0, 1);
        step(5'b00100, 0, 0, 6, 0, 0, 1);
        step(5'b00100, 0, 0, 8, 0, 0, 1);                 // back-to-back MUL
        step(5'b00000, 0, 0, 0, 0, 0, 1);
        for (int k = 0; k < 5 && sb.size() > 0; k++) @(posedge clk);
        if (sb.size() != 0) begin
            compared++;
            mismatched++;
            $display("FAIL drain: %0d expectations left want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
